logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised successor to the fixed 32-bit AND/OR gate arrays in the soft-processor datapath.
- Performs one of eight bitwise operations on two WIDTH-bit operands through a 2-stage pipeline with valid/ready flow control on both sides.
- Produces result flags and a count of completed operations.
- Sits between the register-read stage and the writeback mux as the ALU's logic lane.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/op present.
- in_ready  output  1  block accepts this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation select (encoding in package).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts.
- out_result  output  WIDTH  operation result.
- out_zero  output  1  result == 0.
- out_ones  output  1  result is all ones.
- out_parity  output  1  XOR-reduction of result (1 = odd).
- done_cnt  output  CNT_W  number of results consumed since reset.

Behaviour:
- Ops (in_op):
  - 0 AND: a&b.
  - 1 OR: a|b.
  - 2 XOR: a^b.
  - 3 NOR: ~(a|b).
  - 4 NAND: ~(a&b).
  - 5 XNOR: ~(a^b).
  - 6 ANDN: a&~b.
  - 7 PASSA: a.
  - All ops are bitwise, full WIDTH, no carries.
- Stage 1 (S1): registers a, b, op and s1_valid on input handshake (in_valid && in_ready).
- Stage 2 (S2): computes result and flags from S1 registers; registers them into the output regs with s2_valid = out_valid.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational, no combinational path from in_valid).
- Latency: exactly 2 cycles from input handshake to out_valid when there is no backpressure. Throughput is 1 op/cycle.
- Backpressure:
  - With out_ready low and both stages full, in_ready = 0.
  - Held S1/S2 contents stay stable; no op is lost or duplicated.
  - out_result and flags stay constant while out_valid && !out_ready.
- Simultaneous events: when out_ready and in_valid are both high with the pipe full, S2 takes S1, S1 takes the new input, and in_ready = 1 in the same cycle.
- Bubbles: S2 loads s2_valid = 0 when S1 is empty and s2_adv is high. Data regs may hold stale values, but out_valid = 0.
- done_cnt:
  - Increments by 1 on each output handshake (out_valid && out_ready).
  - Wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- Reset values (async assert, release synchronous to clk):
  - s1_valid = 0, out_valid = 0.
  - out_result = 0, out_zero = 1, out_ones = 0, out_parity = 0.
  - done_cnt = 0.
  - in_ready = 1 after reset.
- Reset mid-operation: all in-flight ops are discarded with no output handshake, and done_cnt clears.
- Illegal input: none possible; all 8 op codes are defined.
- Flags are computed from the registered result's next value, so they are aligned with out_result on the same cycle.

Decomposition:
- Package logic_unit_pkg holds:
  - The op encoding constants (OP_AND..OP_PASSA, 3-bit).
  - The op width constant.
  - A function logic_op(a, b, op) returning the WIDTH result, reusable by the ALU model.
- One sub-module, logic_flags, is natural: combinational zero/ones/parity from a WIDTH vector, parametrised on WIDTH.
- Pipeline registers and handshake live in the top.

Test Plan:
- Reset then single op: a=0xF0F0F0F0, b=0xFF00FF00, op=AND, out_ready=1 → 2 cycles later out_result=0xF000F000, zero=0, ones=0, parity=0, done_cnt=1.
- Back-to-back stream, out_ready=1: OR, XOR, ANDN on the same operands on consecutive cycles → results 0xFFF0FFF0, 0x0FF00FF0, 0x00F000F0 on consecutive cycles, in_ready held at 1.
- Flags: NOR with a=b=0 → result=0xFFFFFFFF, ones=1, parity=0. XNOR with a=0, b=1 → 0xFFFFFFFE, parity=1. AND with a=0 → zero=1.
- Backpressure: out_ready=0 with 3 ops offered → two accepted, in_ready=0 on the third, out_result stable. Then raise out_ready → all 3 results delivered in order, none repeated.
- Counter wrap with CNT_W=4: 17 handshakes → done_cnt sequence reaches 15, then 0, then 1.
- Mid-flight reset: assert rst_n=0 with both stages full → out_valid=0, done_cnt=0, out_zero=1 immediately (async). After release, the next op emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic lane: op encoding and the
// per-bit operation function used by the datapath and by reference models.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NOR   = 3'd3,
    OP_NAND  = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

  // Every op is purely bitwise, so defining it on one bit lets any width
  // apply it with a simple loop and keeps all widths exact.
  function automatic logic logic_op(input logic a, input logic b, input op_e op);
    logic r;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOR:   r = ~(a | b);
      OP_NAND:  r = ~(a & b);
      OP_XNOR:  r = ~(a ^ b);
      OP_ANDN:  r = a & ~b;
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_flags.sv
// Combinational result flags: all-zero, all-ones and odd parity of a vector.
module logic_flags #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] vec,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  assign zero   = ~|vec;
  assign ones   = &vec;
  assign parity = ^vec;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic lane with valid/ready flow control, result flags
// and a counter of results consumed downstream.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [CNT_W-1:0] done_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] res_d;
  logic             zero_d;
  logic             ones_d;
  logic             parity_d;

  // A stage may move when its successor is empty or draining this cycle;
  // in_ready depends only on state and out_ready, never on in_valid.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // NOTE: always_comb outputs get a default before any conditional or loop
  // assignment so no path leaves them unassigned (which would infer a latch).
  always_comb begin
    res_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res_d[i] = logic_op(s1_a[i], s1_b[i], s1_op);
    end
  end

  // Flags come from the next result value so they register alongside it.
  logic_flags #(
    .WIDTH (WIDTH)
  ) u_flags (
    .vec    (res_d),
    .zero   (zero_d),
    .ones   (ones_d),
    .parity (parity_d)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values and stage order within the block cannot matter.
  // NOTE: the data registers are reset too; it costs little here and keeps
  // the published reset values of the result and flags well defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= op_e'(in_op);
      end
    end
  end

  // A bubble in S1 clears out_valid but leaves the data registers stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b1;
      out_ones   <= 1'b0;
      out_parity <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_d;
        out_zero   <= zero_d;
        out_ones   <= ones_d;
        out_parity <= parity_d;
      end
    end
  end

  // Counts output handshakes; wraps silently at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: reset, each op, streaming,
// backpressure, counter wrap (CNT_W=4) and asynchronous reset mid-flight.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [2:0]    in_op = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_result;
  logic          out_zero;
  logic          out_ones;
  logic          out_parity;
  logic [CW-1:0] done_cnt;

  int total = 0;
  int bad   = 0;

  logic_unit_pipe #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_ones   (out_ones),
    .out_parity (out_parity),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issues one op into an empty pipe with out_ready high and checks the
  // fixed 2-cycle latency, result, flags and that it is delivered once.
  task automatic single_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op, input logic [W-1:0] exp,
                           input logic ez, input logic eo, input logic ep,
                           input string name);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s in_ready: got %b want 1", name, in_ready); end
    step;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s early out_valid: got %b want 0", name, out_valid); end
    step;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s out_valid: got %b want 1", name, out_valid); end
    total++; if (out_result !== exp) begin bad++; $display("FAIL %s result: got %h want %h", name, out_result, exp); end
    total++; if (out_zero !== ez) begin bad++; $display("FAIL %s zero: got %b want %b", name, out_zero, ez); end
    total++; if (out_ones !== eo) begin bad++; $display("FAIL %s ones: got %b want %b", name, out_ones, eo); end
    total++; if (out_parity !== ep) begin bad++; $display("FAIL %s parity: got %b want %b", name, out_parity, ep); end
    step;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s repeat out_valid: got %b want 0", name, out_valid); end
  endtask

  task automatic test_reset;
    apply_reset;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    total++; if (out_result !== '0) begin bad++; $display("FAIL reset result: got %h want 0", out_result); end
    total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL reset zero: got %b want 1", out_zero); end
    total++; if (out_ones !== 1'b0) begin bad++; $display("FAIL reset ones: got %b want 0", out_ones); end
    total++; if (out_parity !== 1'b0) begin bad++; $display("FAIL reset parity: got %b want 0", out_parity); end
    total++; if (done_cnt !== 4'd0) begin bad++; $display("FAIL reset done_cnt: got %0d want 0", done_cnt); end
  endtask

  task automatic test_single_and;
    out_ready = 1'b1;
    single_op(32'hF0F0F0F0, 32'hFF00FF00, OP_AND, 32'hF000F000, 1'b0, 1'b0, 1'b0, "and");
    total++; if (done_cnt !== 4'd1) begin bad++; $display("FAIL and done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [2:0]   ops [3] = '{OP_OR, OP_XOR, OP_ANDN};
    logic [W-1:0] exp [3] = '{32'hFFF0FFF0, 32'h0FF00FF0, 32'h00F000F0};
    out_ready = 1'b1;
    in_a = 32'hF0F0F0F0;
    in_b = 32'hFF00FF00;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        in_valid = 1'b1;
        in_op    = ops[i];
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b in_ready[%0d]: got %b want 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      step;
      if (i >= 1 && i <= 3) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b out_valid[%0d]: got %b want 1", i, out_valid); end
        total++; if (out_result !== exp[i-1]) begin bad++; $display("FAIL b2b result[%0d]: got %h want %h", i, out_result, exp[i-1]); end
      end else begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b out_valid[%0d]: got %b want 0", i, out_valid); end
      end
    end
    total++; if (done_cnt !== 4'd4) begin bad++; $display("FAIL b2b done_cnt: got %0d want 4", done_cnt); end
  endtask

  task automatic test_flags;
    out_ready = 1'b1;
    single_op(32'h00000000, 32'h00000000, OP_NOR,   32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, "nor");
    single_op(32'h00000000, 32'h00000001, OP_XNOR,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, "xnor");
    single_op(32'h00000000, 32'hFFFFFFFF, OP_AND,   32'h00000000, 1'b1, 1'b0, 1'b0, "and0");
    single_op(32'hF0F0F0F0, 32'hFF00FF00, OP_NAND,  32'h0FFF0FFF, 1'b0, 1'b0, 1'b0, "nand");
    single_op(32'hF0F0F0F1, 32'hFF00FF00, OP_PASSA, 32'hF0F0F0F1, 1'b0, 1'b0, 1'b1, "passa");
    total++; if (done_cnt !== 4'd9) begin bad++; $display("FAIL flags done_cnt: got %0d want 9", done_cnt); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_a = 32'hF0F0F0F0;
    in_b = 32'hFF00FF00;
    in_valid = 1'b1; in_op = OP_XOR;
    step;
    in_op = OP_NOR;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp in_ready op2: got %b want 1", in_ready); end
    step;
    in_op = OP_XNOR;
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp in_ready full[%0d]: got %b want 0", i, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp out_valid[%0d]: got %b want 1", i, out_valid); end
      total++; if (out_result !== 32'h0FF00FF0) begin bad++; $display("FAIL bp held result[%0d]: got %h want 0ff00ff0", i, out_result); end
      total++; if (done_cnt !== 4'd9) begin bad++; $display("FAIL bp held done_cnt[%0d]: got %0d want 9", i, done_cnt); end
      if (i < 2) step;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp in_ready release: got %b want 1", in_ready); end
    step;
    in_valid = 1'b0;
    total++; if (out_result !== 32'h000F000F) begin bad++; $display("FAIL bp result op2: got %h want 000f000f", out_result); end
    total++; if (done_cnt !== 4'd10) begin bad++; $display("FAIL bp done_cnt op1: got %0d want 10", done_cnt); end
    step;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp out_valid op3: got %b want 1", out_valid); end
    total++; if (out_result !== 32'hF00FF00F) begin bad++; $display("FAIL bp result op3: got %h want f00ff00f", out_result); end
    step;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp drained out_valid: got %b want 0", out_valid); end
    total++; if (done_cnt !== 4'd12) begin bad++; $display("FAIL bp done_cnt: got %0d want 12", done_cnt); end
  endtask

  // Op issued before edge i completes its handshake on edge i+2, so after
  // edge i the count is i-1 (from i=2) and out_result holds operand i-1.
  task automatic test_counter_wrap;
    logic [CW-1:0] exp_cnt;
    apply_reset;
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (i < 17) begin
        in_valid = 1'b1; in_op = OP_PASSA; in_a = W'(i); in_b = ~W'(i);
      end else begin
        in_valid = 1'b0;
      end
      step;
      exp_cnt = (i >= 2) ? CW'(i - 1) : '0;
      total++; if (done_cnt !== exp_cnt) begin bad++; $display("FAIL wrap done_cnt[%0d]: got %0d want %0d", i, done_cnt, exp_cnt); end
      if (i >= 1 && i <= 17) begin
        total++; if (out_result !== W'(i - 1)) begin bad++; $display("FAIL wrap result[%0d]: got %h want %h", i, out_result, W'(i - 1)); end
      end
    end
    total++; if (done_cnt !== 4'd1) begin bad++; $display("FAIL wrap final done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_midflight_reset;
    out_ready = 1'b0;
    in_a = 32'h12345678; in_b = 32'h0F0F0F0F;
    in_valid = 1'b1; in_op = OP_XOR;
    step;
    in_op = OP_OR;
    step;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid full in_ready: got %b want 0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid async out_valid: got %b want 0", out_valid); end
    total++; if (done_cnt !== 4'd0) begin bad++; $display("FAIL mid async done_cnt: got %0d want 0", done_cnt); end
    total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL mid async zero: got %b want 1", out_zero); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid async in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid discarded out_valid[%0d]: got %b want 0", i, out_valid); end
    end
    single_op(32'h00000007, 32'h00000000, OP_XOR, 32'h00000007, 1'b0, 1'b0, 1'b1, "post_reset");
    total++; if (done_cnt !== 4'd1) begin bad++; $display("FAIL mid done_cnt: got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset;
    test_single_and;
    test_back_to_back;
    test_flags;
    test_backpressure;
    test_counter_wrap;
    test_midflight_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
